// File: rtl/result_drain_pkg.sv
// result_drain_pkg: shared types and constants for the result drain stage.
//   drain_state_t  : serializer FSM states (IDLE, SEND)
//   SET_A/B/C      : source channel codes carried with every row
//   beats_per_row(): number of output beats needed for one row
package result_drain_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } drain_state_t;

  localparam logic [1:0] SET_A = 2'd0;
  localparam logic [1:0] SET_B = 2'd1;
  localparam logic [1:0] SET_C = 2'd2;

  localparam int unsigned SET_W  = 2;
  localparam int unsigned ADDR_W = 6;

  function automatic int unsigned beats_per_row(input int unsigned row_w,
                                                input int unsigned beat_w);
    return row_w / beat_w;
  endfunction

endpackage

// File: rtl/result_row_fifo.sv
// result_row_fifo: register-based row FIFO with same-cycle push/pop.
//   clk, arst     : clock, asynchronous active-high reset (pointers/level only)
//   push, pop     : write/read strobes; caller guarantees push only when there
//                   is room (or a pop in the same cycle) and pop only when
//                   non-empty
//   wdata / rdata : entry in / head entry out (rdata is the current head)
//   level         : entries queued; empty / full status
module result_row_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  assign rdata = mem[rd_ptr];
  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));

  // Storage carries no reset: contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/result_drain.sv
// result_drain: captures finished rows from the three subarray write channels
// into a row FIFO and serialises each row into BEAT_WIDTH beats on a
// valid/ready stream (element 0 first).
//   clk, arst                 : clock, asynchronous active-high reset
//   tpu_start / tpu_done      : run start (clears flags/stats) / upstream done
//   sram_write_enable_{a,b,c}0, sram_wdata_*, sram_waddr_* : row writes
//   m_valid/m_ready/m_data/m_last/m_set/m_addr : beat stream out
//   fifo_level                : rows queued
//   overflow / collide        : sticky drop flags
//   drain_done                : sticky, run fully drained
// Optional: `RESULT_DRAIN_STATS_EN adds rows_out / rows_dropped counters.
module result_drain
  import result_drain_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE        = 128,
  parameter int unsigned OUTPUT_DATA_WIDTH = 24,
  parameter int unsigned BEAT_WIDTH        = 256,
  parameter int unsigned FIFO_DEPTH        = 4
) (
  input  logic                                   clk,
  input  logic                                   arst,
  input  logic                                   tpu_start,
  input  logic                                   tpu_done,
  input  logic                                   sram_write_enable_a0,
  input  logic                                   sram_write_enable_b0,
  input  logic                                   sram_write_enable_c0,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_wdata_a,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_wdata_b,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_wdata_c,
  input  logic [5:0]                             sram_waddr_a,
  input  logic [5:0]                             sram_waddr_b,
  input  logic [5:0]                             sram_waddr_c,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic [BEAT_WIDTH-1:0]                  m_data,
  output logic                                   m_last,
  output logic [1:0]                             m_set,
  output logic [5:0]                             m_addr,
  output logic [$clog2(FIFO_DEPTH):0]            fifo_level,
  output logic                                   overflow,
  output logic                                   collide,
  output logic                                   drain_done
`ifdef RESULT_DRAIN_STATS_EN
 ,output logic [15:0]                            rows_out,
  output logic [15:0]                            rows_dropped
`endif
);

  localparam int unsigned ROW_W = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
  localparam int unsigned BPR   = beats_per_row(ROW_W, BEAT_WIDTH);
  localparam int unsigned CNT_W = (BPR > 1) ? $clog2(BPR) : 1;
  localparam int unsigned ENT_W = SET_W + ADDR_W + ROW_W;

  // ---------------- capture ----------------
  logic              any_wr;
  logic [1:0]        n_strobe;
  logic [SET_W-1:0]  sel_set;
  logic [ADDR_W-1:0] sel_addr;
  logic [ROW_W-1:0]  sel_row;

  always_comb begin
    sel_set  = SET_A;
    sel_addr = '0;
    sel_row  = '0;
    if (sram_write_enable_a0) begin
      sel_set  = SET_A;
      sel_addr = sram_waddr_a;
      sel_row  = sram_wdata_a;
    end else if (sram_write_enable_b0) begin
      sel_set  = SET_B;
      sel_addr = sram_waddr_b;
      sel_row  = sram_wdata_b;
    end else if (sram_write_enable_c0) begin
      sel_set  = SET_C;
      sel_addr = sram_waddr_c;
      sel_row  = sram_wdata_c;
    end
    any_wr   = sram_write_enable_a0 | sram_write_enable_b0 | sram_write_enable_c0;
    n_strobe = {1'b0, sram_write_enable_a0} + {1'b0, sram_write_enable_b0}
             + {1'b0, sram_write_enable_c0};
  end

  // ---------------- FIFO ----------------
  logic             fifo_empty;
  logic             fifo_full;
  logic [ENT_W-1:0] fifo_rdata;
  logic             pop;
  logic             push_ok;
  logic             ovf_evt;
  logic             collide_evt;
  logic             beat_fire;
  logic             last_fire;

  drain_state_t     state;
  logic [ROW_W-1:0] row_sr;
  logic [CNT_W-1:0] beat_cnt;

  assign beat_fire   = m_valid & m_ready;
  assign last_fire   = beat_fire & m_last;
  // A pop on the final accepted beat keeps rows back-to-back with no bubble.
  assign pop         = ~fifo_empty & ((state == IDLE) | last_fire);
  // A full FIFO still takes the row when the head leaves in the same cycle.
  assign push_ok     = any_wr & (~fifo_full | pop);
  assign ovf_evt     = any_wr & ~push_ok;
  assign collide_evt = (n_strobe > 2'd1);

  result_row_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .arst  (arst),
    .push  (push_ok),
    .pop   (pop),
    .wdata ({sel_set, sel_addr, sel_row}),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // ---------------- serializer ----------------
  // The row is held in a shift register so the current beat is always the
  // low slice; each accepted beat shifts the next one into place.
  assign m_data = row_sr[BEAT_WIDTH-1:0];
  assign m_last = m_valid & (beat_cnt == CNT_W'(BPR - 1));

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state    <= IDLE;
      m_valid  <= 1'b0;
      row_sr   <= '0;
      beat_cnt <= '0;
      m_set    <= '0;
      m_addr   <= '0;
    end else begin
      if (pop) begin
        state    <= SEND;
        m_valid  <= 1'b1;
        {m_set, m_addr, row_sr} <= fifo_rdata;
        beat_cnt <= '0;
      end else if (last_fire) begin
        state    <= IDLE;
        m_valid  <= 1'b0;
        row_sr   <= row_sr >> BEAT_WIDTH;
        beat_cnt <= '0;
      end else if (beat_fire) begin
        row_sr   <= row_sr >> BEAT_WIDTH;
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------- flags / done ----------------
  logic done_seen;
  logic drain_cond;

  assign drain_cond = done_seen & fifo_empty & (state == IDLE) & ~any_wr;

  // Events in a tpu_start cycle belong to the new run, so they survive the clear.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      done_seen  <= 1'b0;
      drain_done <= 1'b0;
      overflow   <= 1'b0;
      collide    <= 1'b0;
    end else begin
      overflow <= (overflow & ~tpu_start) | ovf_evt;
      collide  <= (collide  & ~tpu_start) | collide_evt;
      if (tpu_start) begin
        done_seen  <= 1'b0;
        drain_done <= 1'b0;
      end else begin
        if (tpu_done)   done_seen  <= 1'b1;
        if (drain_cond) drain_done <= 1'b1;
      end
    end
  end

`ifdef RESULT_DRAIN_STATS_EN
  logic [1:0]  lost_now;
  logic [2:0]  drop_inc;
  logic [16:0] out_sum;
  logic [16:0] drop_sum;

  always_comb begin
    lost_now = any_wr ? (n_strobe - 2'd1) : 2'd0;
    drop_inc = {1'b0, lost_now} + {2'b00, ovf_evt};
    out_sum  = {1'b0, (tpu_start ? 16'h0000 : rows_out)} + {16'h0000, last_fire};
    drop_sum = {1'b0, (tpu_start ? 16'h0000 : rows_dropped)} + {14'h0000, drop_inc};
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rows_out     <= '0;
      rows_dropped <= '0;
    end else begin
      rows_out     <= out_sum[16]  ? '1 : out_sum[15:0];
      rows_dropped <= drop_sum[16] ? '1 : drop_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_result_drain.sv
// tb_result_drain: directed bench for result_drain (4x24-bit rows, 32-bit
// beats, 3 beats per row, 4-row FIFO). Expected beats are queued when a row
// is written and checked as the DUT hands them over.
module tb_result_drain;
  import result_drain_pkg::*;

  localparam int unsigned AS  = 4;
  localparam int unsigned ODW = 24;
  localparam int unsigned BW  = 32;
  localparam int unsigned FD  = 4;
  localparam int unsigned RW  = AS * ODW;
  localparam int unsigned BPR = RW / BW;

  typedef struct packed {
    logic [BW-1:0] data;
    logic          last;
    logic [1:0]    set;
    logic [5:0]    addr;
  } beat_t;

  logic          clk = 1'b0;
  logic          arst;
  logic          tpu_start, tpu_done;
  logic          we_a, we_b, we_c;
  logic [RW-1:0] wd_a, wd_b, wd_c;
  logic [5:0]    wa_a, wa_b, wa_c;
  logic          m_valid, m_ready, m_last;
  logic [BW-1:0] m_data;
  logic [1:0]    m_set;
  logic [5:0]    m_addr;
  logic [2:0]    fifo_level;
  logic          overflow, collide, drain_done;
`ifdef RESULT_DRAIN_STATS_EN
  logic [15:0]   rows_out, rows_dropped;
`endif

  beat_t sb[$];
  int    vectors  = 0;
  int    errs     = 0;
  int    beats_acc = 0;

  always #5 clk = ~clk;

  result_drain #(
    .ARRAY_SIZE        (AS),
    .OUTPUT_DATA_WIDTH (ODW),
    .BEAT_WIDTH        (BW),
    .FIFO_DEPTH        (FD)
  ) dut (
    .clk                  (clk),
    .arst                 (arst),
    .tpu_start            (tpu_start),
    .tpu_done             (tpu_done),
    .sram_write_enable_a0 (we_a),
    .sram_write_enable_b0 (we_b),
    .sram_write_enable_c0 (we_c),
    .sram_wdata_a         (wd_a),
    .sram_wdata_b         (wd_b),
    .sram_wdata_c         (wd_c),
    .sram_waddr_a         (wa_a),
    .sram_waddr_b         (wa_b),
    .sram_waddr_c         (wa_c),
    .m_valid              (m_valid),
    .m_ready              (m_ready),
    .m_data               (m_data),
    .m_last               (m_last),
    .m_set                (m_set),
    .m_addr               (m_addr),
    .fifo_level           (fifo_level),
    .overflow             (overflow),
    .collide              (collide),
    .drain_done           (drain_done)
`ifdef RESULT_DRAIN_STATS_EN
   ,.rows_out             (rows_out),
    .rows_dropped         (rows_dropped)
`endif
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: score any beat accepted at this edge, then verify a stalled
  // beat is still presented unchanged afterwards.
  task automatic tick();
    bit    hold;
    beat_t e;
    hold = (m_valid === 1'b1) && (m_ready === 1'b0) && (sb.size() > 0);
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      beats_acc++;
      if (sb.size() == 0) begin
        check("extra_beat_valid", m_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        check("beat_data", m_data, e.data);
        check("beat_last", m_last, e.last);
        check("beat_set",  m_set,  e.set);
        check("beat_addr", m_addr, e.addr);
      end
    end
    @(posedge clk);
    #1;
    if (hold) begin
      check("stall_valid", m_valid, 1'b1);
      check("stall_data",  m_data,  sb[0].data);
      check("stall_last",  m_last,  sb[0].last);
    end
  endtask

  task automatic expect_row(input int ch, input logic [RW-1:0] row, input logic [5:0] addr);
    beat_t b;
    for (int k = 0; k < int'(BPR); k++) begin
      b.data = row[k*BW +: BW];
      b.last = (k == int'(BPR) - 1);
      b.set  = 2'(ch);
      b.addr = addr;
      sb.push_back(b);
    end
  endtask

  task automatic put_row(input int ch, input logic [RW-1:0] row, input logic [5:0] addr,
                         input bit expect_out);
    case (ch)
      0:       begin we_a = 1'b1; wd_a = row; wa_a = addr; end
      1:       begin we_b = 1'b1; wd_b = row; wa_b = addr; end
      default: begin we_c = 1'b1; wd_c = row; wa_c = addr; end
    endcase
    if (expect_out) expect_row(ch, row, addr);
    tick();
    we_a = 1'b0; we_b = 1'b0; we_c = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && sb.size() > 0; i++) tick();
    check(tag, sb.size(), 0);
  endtask

  task automatic pulse_start();
    tpu_start = 1'b1;
    tick();
    tpu_start = 1'b0;
  endtask

  function automatic logic [RW-1:0] rnd_row();
    return {$urandom, $urandom, $urandom};
  endfunction

  logic [RW-1:0] r0;
  logic [RW-1:0] rc;

  initial begin
    arst = 1'b1; tpu_start = 1'b0; tpu_done = 1'b0; m_ready = 1'b0;
    we_a = 1'b0; we_b = 1'b0; we_c = 1'b0;
    wd_a = '0; wd_b = '0; wd_c = '0; wa_a = '0; wa_b = '0; wa_c = '0;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    check("rst_valid", m_valid, 1'b0);
    check("rst_data", m_data, 32'h0);
    check("rst_last", m_last, 1'b0);
    check("rst_set", m_set, 2'd0);
    check("rst_addr", m_addr, 6'd0);
    check("rst_level", fifo_level, 3'd0);
    check("rst_flags", {overflow, collide, drain_done}, 3'b000);
`ifdef RESULT_DRAIN_STATS_EN
    check("rst_stats", {rows_out, rows_dropped}, 32'h0);
`endif
    arst = 1'b0;
    tick();

    // single a-row, addr 5, two cycles to first beat
    m_ready = 1'b1;
    r0 = 96'h00000C_00000B_00000A_000009;
    put_row(0, r0, 6'd5, 1'b1);
    check("lat_valid_t0", m_valid, 1'b0);
    check("lat_level_t0", fifo_level, 3'd1);
    tick();
    check("lat_valid_t1", m_valid, 1'b1);
    check("first_beat", m_data, 32'h0A000009);
    drain("single_drain", 10);
    check("single_idle", m_valid, 1'b0);

    // three rows, ready toggling
    m_ready = 1'b0;
    beats_acc = 0;
    put_row(1, rnd_row(), 6'd10, 1'b1);
    put_row(2, rnd_row(), 6'd11, 1'b1);
    put_row(0, rnd_row(), 6'd12, 1'b1);
    for (int i = 0; i < 60 && sb.size() > 0; i++) begin
      m_ready = (i % 2 == 0);
      tick();
    end
    check("toggle_drain", sb.size(), 0);
    check("toggle_beats", beats_acc, 9);

    // overflow: one row moves into the serializer, so five rows are held
    // (four queued) and the sixth is dropped
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) put_row(i % 3, rnd_row(), 6'(20 + i), i < 5);
    check("ovf_level", fifo_level, 3'd4);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_collide", collide, 1'b0);
`ifdef RESULT_DRAIN_STATS_EN
    check("ovf_dropped", rows_dropped, 16'd1);
`endif
    m_ready = 1'b1;
    beats_acc = 0;
    drain("ovf_drain", 40);
    check("ovf_beats", beats_acc, 15);

    // collision: a and c together, only a survives
    pulse_start();
    check("start_clr_ovf", overflow, 1'b0);
    r0 = rnd_row();
    rc = rnd_row();
    we_a = 1'b1; wd_a = r0; wa_a = 6'd7;
    we_c = 1'b1; wd_c = rc; wa_c = 6'd9;
    expect_row(0, r0, 6'd7);
    tick();
    we_a = 1'b0; we_c = 1'b0;
    check("coll_flag", collide, 1'b1);
    check("coll_level", fifo_level, 3'd1);
`ifdef RESULT_DRAIN_STATS_EN
    check("coll_dropped", rows_dropped, 16'd1);
`endif
    drain("coll_drain", 20);
    repeat (4) tick();
    check("coll_no_c", m_valid, 1'b0);

    // drain_done with two rows queued
    pulse_start();
    check("start_clr_coll", collide, 1'b0);
    m_ready = 1'b0;
    put_row(1, rnd_row(), 6'd30, 1'b1);
    put_row(2, rnd_row(), 6'd31, 1'b1);
    tpu_done = 1'b1;
    tick();
    tpu_done = 1'b0;
    check("done_stalled", drain_done, 1'b0);
    m_ready = 1'b1;
    beats_acc = 0;
    for (int i = 0; i < 40 && sb.size() > 0; i++) begin
      tick();
      if (sb.size() > 0) check("done_early", drain_done, 1'b0);
    end
    check("done_beats", beats_acc, 6);
    check("done_after_last", drain_done, 1'b0);
    tick();
    check("done_rise", drain_done, 1'b1);
`ifdef RESULT_DRAIN_STATS_EN
    check("rows_out", rows_out, 16'd2);
`endif
    pulse_start();
    check("done_cleared", drain_done, 1'b0);

    // async reset mid-row: beat 2 abandoned, queued row lost
    m_ready = 1'b0;
    r0 = rnd_row();
    put_row(0, r0, 6'd40, 1'b0);
    put_row(1, rnd_row(), 6'd41, 1'b0);
    check("arst_pre_level", fifo_level, 3'd1);
    sb.push_back('{data: r0[BW-1:0], last: 1'b0, set: 2'd0, addr: 6'd40});
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("arst_pre_valid", m_valid, 1'b1);
    arst = 1'b1;
    #1;
    check("arst_valid", m_valid, 1'b0);
    check("arst_data", m_data, 32'h0);
    check("arst_meta", {m_last, m_set, m_addr}, 9'h0);
    check("arst_level", fifo_level, 3'd0);
    tick();
    arst = 1'b0;
    tick();
    m_ready = 1'b1;
    put_row(2, rnd_row(), 6'd50, 1'b1);
    drain("post_arst_drain", 20);
    repeat (4) tick();
    check("post_arst_idle", m_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
